// File: rtl/phase_serdes8.sv
// Byte serializer/deserializer clocked by an 8-phase one-hot ring: one byte out and
// one byte in per ring revolution, with ring-sequence checking that aborts frames.
module phase_serdes8 #(
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] PHASE,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       SER_OUT,
    input  logic       SER_IN,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       FRAME,
    output logic       TX_UNDERRUN,
    output logic       PHASE_ERR,
    input  logic       ERR_CLR,
    output logic [3:0] DBG_TRACK
);

    // Phase tracker: MSB marks "a phase was seen", low bits hold that phase index.
    typedef enum logic [3:0] {
        TRK_NONE = 4'b0000,
        TRK_P0   = 4'b1000,
        TRK_P1   = 4'b1001,
        TRK_P2   = 4'b1010,
        TRK_P3   = 4'b1011,
        TRK_P4   = 4'b1100,
        TRK_P5   = 4'b1101,
        TRK_P6   = 4'b1110,
        TRK_P7   = 4'b1111
    } trk_e;

    trk_e       trk_q, trk_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] txsh_q, txsh_d;
    logic       frame_q, frame_d;
    logic       ser_out_q, ser_out_d;
    logic [7:0] rxsh_q, rxsh_d;
    logic       rx_ok_q, rx_ok_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       underrun_q, underrun_d;
    logic       phase_err_q, phase_err_d;

    logic [2:0] phase_idx;
    logic       phase_multi;
    logic       phase_bad;
    logic       accept;
    logic       under_set;
    logic       err_set;

    // Maps a phase slot to the data bit it carries.
    function automatic logic [2:0] bmap(input logic [2:0] k);
        return LSB_FIRST ? k : (3'd7 - k);
    endfunction

    always_comb begin
        phase_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (PHASE[i]) phase_idx = 3'(i);
        end
    end

    assign phase_multi = |(PHASE & (PHASE - 8'd1));
    assign phase_bad   = (PHASE != 8'd0) &&
                         (phase_multi ||
                          ((trk_q == TRK_NONE) ? (phase_idx != 3'd0)
                                               : (phase_idx != (trk_q[2:0] + 3'd1))));
    assign accept      = TX_VALID & ~hold_full_q;

    always_comb begin
        trk_d       = trk_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        txsh_d      = txsh_q;
        frame_d     = frame_q;
        ser_out_d   = ser_out_q;
        rxsh_d      = rxsh_q;
        rx_ok_d     = rx_ok_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        under_set   = 1'b0;
        err_set     = 1'b0;

        if (PHASE == 8'd0) begin
            trk_d     = TRK_NONE;
            frame_d   = 1'b0;
            ser_out_d = IDLE_LEVEL;
            rx_ok_d   = 1'b0;
        end else if (phase_bad) begin
            // Abort: the shift register contents are abandoned, the hold byte survives.
            err_set   = 1'b1;
            trk_d     = TRK_NONE;
            frame_d   = 1'b0;
            ser_out_d = IDLE_LEVEL;
            rx_ok_d   = 1'b0;
            rxsh_d    = 8'd0;
        end else begin
            trk_d                    = trk_e'({1'b1, phase_idx});
            rxsh_d[bmap(phase_idx)]  = SER_IN;
            if (phase_idx == 3'd0) begin
                rx_ok_d = 1'b1;
                if (hold_full_q) begin
                    txsh_d      = hold_q;
                    hold_full_d = 1'b0;
                    frame_d     = 1'b1;
                    ser_out_d   = hold_q[bmap(3'd0)];
                end else begin
                    frame_d   = 1'b0;
                    ser_out_d = IDLE_LEVEL;
                    under_set = frame_q;
                end
            end else begin
                ser_out_d = frame_q ? txsh_q[bmap(phase_idx)] : IDLE_LEVEL;
            end
            if (phase_idx == 3'd7) begin
                rx_data_d             = rxsh_q;
                rx_data_d[bmap(3'd7)] = SER_IN;
                rx_valid_d            = rx_ok_q;
                rx_ok_d               = 1'b0;
            end
        end

        // A phase-0 accept lands in hold only; the byte leaves on the next frame.
        if (accept) begin
            hold_d      = TX_DATA;
            hold_full_d = 1'b1;
        end

        underrun_d  = (underrun_q  & ~ERR_CLR) | under_set;
        phase_err_d = (phase_err_q & ~ERR_CLR) | err_set;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            trk_q       <= TRK_NONE;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            txsh_q      <= 8'd0;
            frame_q     <= 1'b0;
            ser_out_q   <= IDLE_LEVEL;
            rxsh_q      <= 8'd0;
            rx_ok_q     <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            phase_err_q <= 1'b0;
        end else begin
            trk_q       <= trk_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            txsh_q      <= txsh_d;
            frame_q     <= frame_d;
            ser_out_q   <= ser_out_d;
            rxsh_q      <= rxsh_d;
            rx_ok_q     <= rx_ok_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            phase_err_q <= phase_err_d;
        end
    end

    assign TX_READY    = ~hold_full_q;
    assign SER_OUT     = ser_out_q;
    assign RX_DATA     = rx_data_q;
    assign RX_VALID    = rx_valid_q;
    assign FRAME       = frame_q;
    assign TX_UNDERRUN = underrun_q;
    assign PHASE_ERR   = phase_err_q;
    assign DBG_TRACK   = trk_q;

endmodule

// File: tb/tb_phase_serdes8.sv
// Bench for phase_serdes8: drives the phase ring, serial input and byte stream,
// and scores SER_OUT bits and received bytes against expected queues.
module tb_phase_serdes8;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] PHASE;
    logic [7:0] tx_data;
    logic       tx_valid0, tx_valid1;
    logic       SER_IN;
    logic       ERR_CLR;

    logic       tx_ready0, ser_out0, rx_valid0, frame0, underrun0, phase_err0;
    logic [7:0] rx_data0;
    logic [3:0] dbg0;
    logic       tx_ready1, ser_out1, rx_valid1, frame1, underrun1, phase_err1;
    logic [7:0] rx_data1;
    logic [3:0] dbg1;

    // sel=0 observes the LSB-first instance, sel=1 the MSB-first instance.
    logic       sel;
    logic       obs_ser_out, obs_rx_valid, obs_frame, obs_tx_ready;
    logic [7:0] obs_rx_data;

    int checks = 0;
    int errors = 0;
    logic [7:0] rx_exp_q[$];
    logic [0:0] tx_exp_q[$];

    phase_serdes8 #(.LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .PHASE(PHASE), .TX_DATA(tx_data), .TX_VALID(tx_valid0),
        .TX_READY(tx_ready0), .SER_OUT(ser_out0), .SER_IN(SER_IN), .RX_DATA(rx_data0),
        .RX_VALID(rx_valid0), .FRAME(frame0), .TX_UNDERRUN(underrun0), .PHASE_ERR(phase_err0),
        .ERR_CLR(ERR_CLR), .DBG_TRACK(dbg0)
    );

    phase_serdes8 #(.LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .PHASE(PHASE), .TX_DATA(tx_data), .TX_VALID(tx_valid1),
        .TX_READY(tx_ready1), .SER_OUT(ser_out1), .SER_IN(SER_IN), .RX_DATA(rx_data1),
        .RX_VALID(rx_valid1), .FRAME(frame1), .TX_UNDERRUN(underrun1), .PHASE_ERR(phase_err1),
        .ERR_CLR(ERR_CLR), .DBG_TRACK(dbg1)
    );

    assign obs_ser_out  = sel ? ser_out1  : ser_out0;
    assign obs_rx_valid = sel ? rx_valid1 : rx_valid0;
    assign obs_rx_data  = sel ? rx_data1  : rx_data0;
    assign obs_frame    = sel ? frame1    : frame0;
    assign obs_tx_ready = sel ? tx_ready1 : tx_ready0;

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int bit_of(input int k, input bit lsb);
        return lsb ? k : (7 - k);
    endfunction

    // Received-byte scoreboard.
    always @(negedge CLK) begin : rx_monitor
        logic [7:0] exp_b;
        if (obs_rx_valid === 1'b1) begin
            checks++;
            if (rx_exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: RX_VALID pulse with RX_DATA=%02h, none expected", obs_rx_data);
            end else begin
                exp_b = rx_exp_q.pop_front();
                if (obs_rx_data !== exp_b) begin
                    errors++;
                    $display("FAIL rx_data: got %02h expected %02h", obs_rx_data, exp_b);
                end
            end
        end
    end

    task automatic step(input logic [7:0] ph, input logic si);
        PHASE  = ph;
        SER_IN = si;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic load_idle(input logic [7:0] b);
        tx_data = b;
        if (sel) tx_valid1 = 1'b1; else tx_valid0 = 1'b1;
        step(8'h00, 1'b0);
        tx_valid0 = 1'b0;
        tx_valid1 = 1'b0;
        checks++;
        if (obs_tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_ready: TX_READY got %b expected 0 after accept of %02h", obs_tx_ready, b);
        end
        for (int k = 0; k < 8; k++) tx_exp_q.push_back(b[bit_of(k, !sel)]);
    endtask

    task automatic run_frame(input logic [7:0] rx_byte, input bit ld, input logic [7:0] ld_byte,
                             input int ld_slot);
        bit         active;
        logic [0:0] exp_bit;
        active = (tx_exp_q.size() >= 8);
        rx_exp_q.push_back(rx_byte);
        for (int k = 0; k < 8; k++) begin
            PHASE  = 8'(1 << k);
            SER_IN = rx_byte[bit_of(k, !sel)];
            if (ld && k == ld_slot) begin
                tx_data = ld_byte;
                if (sel) tx_valid1 = 1'b1; else tx_valid0 = 1'b1;
            end
            @(posedge CLK);
            @(negedge CLK);
            tx_valid0 = 1'b0;
            tx_valid1 = 1'b0;
            exp_bit = active ? tx_exp_q.pop_front() : 1'b1;
            checks++;
            if (obs_ser_out !== exp_bit) begin
                errors++;
                $display("FAIL ser_out slot %0d: got %b expected %b", k, obs_ser_out, exp_bit);
            end
            checks++;
            if (obs_frame !== active) begin
                errors++;
                $display("FAIL frame slot %0d: got %b expected %b", k, obs_frame, active);
            end
            if (k == 0 && active) begin
                checks++;
                if (obs_tx_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_after_load: TX_READY got %b expected 1", obs_tx_ready);
                end
            end
            if (ld && k == ld_slot) begin
                checks++;
                if (obs_tx_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_drop slot %0d: TX_READY got %b expected 0", k, obs_tx_ready);
                end
                for (int j = 0; j < 8; j++) tx_exp_q.push_back(ld_byte[bit_of(j, !sel)]);
            end
        end
    endtask

    task automatic test_reset();
        sel = 1'b0; RESET = 1'b0; PHASE = 8'h00; SER_IN = 1'b0; ERR_CLR = 1'b0;
        tx_data = 8'h00; tx_valid0 = 1'b0; tx_valid1 = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (tx_ready0 !== 1'b1) begin errors++; $display("FAIL rst_tx_ready: got %b expected 1", tx_ready0); end
        checks++; if (ser_out0 !== 1'b1) begin errors++; $display("FAIL rst_ser_out: got %b expected 1", ser_out0); end
        checks++; if (rx_data0 !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %02h expected 00", rx_data0); end
        checks++; if (rx_valid0 !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b expected 0", rx_valid0); end
        checks++; if (frame0 !== 1'b0) begin errors++; $display("FAIL rst_frame: got %b expected 0", frame0); end
        checks++; if ({underrun0, phase_err0} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b%b expected 00", underrun0, phase_err0); end
        checks++; if (dbg0 !== 4'h0) begin errors++; $display("FAIL rst_track: got %h expected 0", dbg0); end
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_first_frame();
        load_idle(8'hA5);
        run_frame(8'hA5, 1'b0, 8'h00, 0);
        checks++;
        if ({underrun0, phase_err0} !== 2'b00) begin
            errors++;
            $display("FAIL t1_flags: got %b%b expected 00", underrun0, phase_err0);
        end
    endtask

    task automatic test_loop_stream();
        load_idle(8'h3C);
        run_frame(8'h3C, 1'b1, 8'hC3, 2);
        run_frame(8'hC3, 1'b0, 8'h00, 0);
        step(8'h00, 1'b0);
        checks++;
        if (underrun0 !== 1'b0) begin
            errors++;
            $display("FAIL t2_underrun: got %b expected 0", underrun0);
        end
    endtask

    task automatic test_msb_first();
        sel = 1'b1;
        load_idle(8'h80);
        run_frame(8'h80, 1'b0, 8'h00, 0);
        step(8'h00, 1'b0);
        sel = 1'b0;
    endtask

    task automatic test_underrun();
        load_idle(8'h55);
        run_frame(8'h55, 1'b0, 8'h00, 0);
        checks++;
        if (underrun0 !== 1'b0) begin errors++; $display("FAIL t4_pre_underrun: got %b expected 0", underrun0); end
        run_frame(8'hE1, 1'b0, 8'h00, 0);
        checks++;
        if (underrun0 !== 1'b1) begin errors++; $display("FAIL t4_underrun: got %b expected 1", underrun0); end
        ERR_CLR = 1'b1;
        step(8'h00, 1'b0);
        ERR_CLR = 1'b0;
        checks++;
        if (underrun0 !== 1'b0) begin errors++; $display("FAIL t4_clear: got %b expected 0", underrun0); end
    endtask

    task automatic test_phase_errors();
        logic [7:0] tail[5];
        logic [0:0] e;
        tail = '{8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        // Multi-hot vector in the phase-2 slot.
        load_idle(8'h5A);
        for (int k = 0; k < 2; k++) begin
            step(8'(1 << k), 1'b0);
            e = tx_exp_q.pop_front();
            checks++;
            if (ser_out0 !== e) begin errors++; $display("FAIL t5a_ser slot %0d: got %b expected %b", k, ser_out0, e); end
        end
        step(8'h0C, 1'b0);
        tx_exp_q.delete();
        checks++;
        if ({phase_err0, frame0, ser_out0} !== 3'b101) begin
            errors++;
            $display("FAIL t5a_abort: err/frame/ser got %b%b%b expected 101", phase_err0, frame0, ser_out0);
        end
        for (int i = 0; i < 5; i++) begin
            ERR_CLR = (i == 0);
            step(tail[i], 1'b0);
            ERR_CLR = 1'b0;
            checks++;
            if ({phase_err0, ser_out0} !== 2'b11) begin
                errors++;
                $display("FAIL t5a_hold_err %0d: err/ser got %b%b expected 11", i, phase_err0, ser_out0);
            end
        end
        ERR_CLR = 1'b1;
        step(8'h00, 1'b0);
        ERR_CLR = 1'b0;
        checks++;
        if (phase_err0 !== 1'b0) begin errors++; $display("FAIL t5a_clear: got %b expected 0", phase_err0); end
        // Skip from phase 4 to phase 6.
        load_idle(8'h96);
        for (int k = 0; k < 5; k++) begin
            step(8'(1 << k), 1'b1);
            e = tx_exp_q.pop_front();
            checks++;
            if (ser_out0 !== e) begin errors++; $display("FAIL t5b_ser slot %0d: got %b expected %b", k, ser_out0, e); end
        end
        step(8'h40, 1'b1);
        tx_exp_q.delete();
        checks++;
        if ({phase_err0, frame0, ser_out0} !== 3'b101) begin
            errors++;
            $display("FAIL t5b_skip: err/frame/ser got %b%b%b expected 101", phase_err0, frame0, ser_out0);
        end
        step(8'h80, 1'b1);
        checks++;
        if ({phase_err0, frame0, ser_out0} !== 3'b101) begin
            errors++;
            $display("FAIL t5b_after: err/frame/ser got %b%b%b expected 101", phase_err0, frame0, ser_out0);
        end
        load_idle(8'h3A);
        run_frame(8'h3A, 1'b0, 8'h00, 0);
        checks++;
        if (phase_err0 !== 1'b1) begin errors++; $display("FAIL t5_sticky: got %b expected 1", phase_err0); end
        ERR_CLR = 1'b1;
        step(8'h00, 1'b0);
        ERR_CLR = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] cur_rx, nxt;
        load_idle(8'($urandom_range(0, 255)));
        for (int i = 0; i < 4; i++) begin
            cur_rx = 8'($urandom_range(0, 255));
            nxt    = 8'($urandom_range(0, 255));
            run_frame(cur_rx, (i < 3), nxt, int'($urandom_range(1, 7)));
        end
        step(8'h00, 1'b0);
        checks++;
        if ({underrun0, phase_err0} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_flags: got %b%b expected 00", underrun0, phase_err0);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [0:0] e;
        load_idle(8'h81);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin tx_data = 8'h42; tx_valid0 = 1'b1; end
            step(8'(1 << k), 1'b1);
            tx_valid0 = 1'b0;
            e = tx_exp_q.pop_front();
            checks++;
            if (ser_out0 !== e) begin errors++; $display("FAIL t6_ser slot %0d: got %b expected %b", k, ser_out0, e); end
        end
        checks++;
        if (tx_ready0 !== 1'b0) begin errors++; $display("FAIL t6_hold_full: TX_READY got %b expected 0", tx_ready0); end
        PHASE = 8'h10;
        RESET = 1'b0;
        #1;
        tx_exp_q.delete();
        checks++;
        if ({tx_ready0, ser_out0, frame0, rx_valid0, underrun0, phase_err0} !== 6'b110000) begin
            errors++;
            $display("FAIL t6_async: ready/ser/frame/rxv/und/err got %b%b%b%b%b%b expected 110000",
                     tx_ready0, ser_out0, frame0, rx_valid0, underrun0, phase_err0);
        end
        checks++;
        if (rx_data0 !== 8'h00) begin errors++; $display("FAIL t6_rx_data: got %02h expected 00", rx_data0); end
        @(posedge CLK);
        @(negedge CLK);
        PHASE = 8'h00;
        RESET = 1'b1;
        step(8'h00, 1'b0);
        checks++;
        if ({phase_err0, tx_ready0} !== 2'b01) begin
            errors++;
            $display("FAIL t6_release: err/ready got %b%b expected 01", phase_err0, tx_ready0);
        end
        load_idle(8'hF0);
        run_frame(8'h0F, 1'b0, 8'h00, 0);
        checks++;
        if (phase_err0 !== 1'b0) begin errors++; $display("FAIL t6_resume_err: got %b expected 0", phase_err0); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_loop_stream();
        test_msb_first();
        test_underrun();
        test_phase_errors();
        test_back_to_back();
        test_reset_mid_frame();
        step(8'h00, 1'b0);
        checks++;
        if (rx_exp_q.size() != 0) begin
            errors++;
            $display("FAIL rx_missing: %0d expected bytes never received, expected 0", rx_exp_q.size());
        end
        checks++;
        if (tx_exp_q.size() != 0) begin
            errors++;
            $display("FAIL tx_leftover: %0d expected bits never sent, expected 0", tx_exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
